// File: rtl/calc_pkg.sv
// Shared calculator definitions: operand width and the multiplier FSM encoding,
// also decoded by the top-level op sequencer.
package calc_pkg;
  localparam int CALC_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } calc_state_e;
endpackage

// File: rtl/mult_add_stage.sv
// Conditional ripple adder for one shift-add iteration: sum = acc_hi + (en ? mcand : 0),
// one bit wider than the operands so the carry feeds the next right shift.
module mult_add_stage #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] mcand,
  input  logic             en,
  output logic [WIDTH:0]   sum
);
  logic carry;
  logic addend;

  always_comb begin
    carry  = 1'b0;
    addend = 1'b0;
    sum    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      addend = mcand[i] & en;
      sum[i] = acc_hi[i] ^ addend ^ carry;
      carry  = (acc_hi[i] & addend) | (carry & (acc_hi[i] ^ addend));
    end
    sum[WIDTH] = carry;
  end
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: WIDTH RUN cycles per product,
// one-cycle done pulse, product and overflow flag held until the next completion.
module seq_shift_add_multiplier
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic               ovf
);
  localparam int CW = $clog2(WIDTH) + 1;

  calc_state_e        state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH:0]     sum;
  logic [3*WIDTH:0]   shift_w;
  logic               last_iter;
  logic               accept;

  mult_add_stage #(.WIDTH(WIDTH)) u_add (
    .acc_hi (acc_q[2*WIDTH-1:WIDTH]),
    .mcand  (mcand_q),
    .en     (mplr_q[0]),
    .sum    (sum)
  );

  // {sum, acc_lo, mplr} >> 1: bit 0 is discarded, the rest splits into acc and mplr
  assign shift_w   = {sum, acc_q[WIDTH-1:0], mplr_q};
  assign last_iter = (count_q == CW'(WIDTH - 1));
  assign accept    = (state_q != RUN) && start;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    count_d = count_q;
    p_d     = p_q;
    ovf_d   = ovf_q;
    if (accept) begin
      mcand_d = a;
      mplr_d  = b;
      acc_d   = '0;
      count_d = '0;
    end else if (state_q == RUN) begin
      acc_d   = shift_w[3*WIDTH:WIDTH+1];
      mplr_d  = shift_w[WIDTH:1];
      count_d = count_q + CW'(1);
      if (last_iter) begin
        p_d   = shift_w[3*WIDTH:WIDTH+1];
        ovf_d = |shift_w[3*WIDTH:2*WIDTH+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      count_q <= '0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
    end
  end

  assign p   = p_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: vector table, directed corner sequences and
// random operands, results checked through an expected-result queue.
module tb_seq_shift_add_multiplier;
  localparam int W = 7;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy, done, ovf;
  logic [2*W-1:0] p;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    logic           ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    logic           ovf;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every done pulse must match the oldest pending op; p must not move otherwise.
  logic [2*W-1:0] p_last;
  logic           reset_last = 1'b1;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        mon_e = sb.pop_front();
        chk("product", 32'(p), 32'(mon_e.p));
        chk("ovf", 32'(ovf), 32'(mon_e.ovf));
      end
    end else if (!reset_last && p !== p_last) begin
      n_err++;
      $display("FAIL p_stability: got %0d expected %0d", p, p_last);
    end
    p_last     = p;
    reset_last = reset;
  end

  task automatic launch(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic [2*W-1:0] ep, input logic eovf, input bit push);
    @(posedge clk); #1;
    a = ai; b = bi; start = 1'b1;
    if (push) sb.push_back('{p: ep, ovf: eovf});
    @(posedge clk); #1;
    start = 1'b0;
    a = 7'($urandom_range(0, 127));
    b = 7'($urandom_range(0, 127));
  endtask

  // Called just after the accepting edge; pulse_cyc>0 re-pulses start mid-run.
  task automatic wait_done(input string name, input int pulse_cyc);
    int cyc = 0;
    int busy_n = 0;
    bit seen = 0;
    while (cyc < 40 && !seen) begin
      @(negedge clk);
      cyc++;
      if (pulse_cyc != 0 && cyc == pulse_cyc) begin
        start = 1'b1; a = 7'd3; b = 7'd3;
      end else if (pulse_cyc != 0 && cyc == pulse_cyc + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) seen = 1;
      else if (busy === 1'b1) busy_n++;
    end
    if (!seen) begin
      n_err++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    end else begin
      chk({name, "_latency"}, 32'(cyc), 32'(W + 1));
      chk({name, "_busy_cycles"}, 32'(busy_n), 32'(W));
      chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    end
  endtask

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0]   ra, rb;
    logic [2*W-1:0] prod;

    vecs[0] = '{a: 7'd12,  b: 7'd10,  p: 14'd120,   ovf: 1'b0};
    vecs[1] = '{a: 7'd127, b: 7'd127, p: 14'h3F01,  ovf: 1'b1};
    vecs[2] = '{a: 7'd0,   b: 7'd85,  p: 14'd0,     ovf: 1'b0};
    vecs[3] = '{a: 7'd1,   b: 7'd127, p: 14'd127,   ovf: 1'b0};
    vecs[4] = '{a: 7'd64,  b: 7'd2,   p: 14'd128,   ovf: 1'b1};
    vecs[5] = '{a: 7'd127, b: 7'd0,   p: 14'd0,     ovf: 1'b0};
    vecs[6] = '{a: 7'd100, b: 7'd100, p: 14'd10000, ovf: 1'b1};
    vecs[7] = '{a: 7'd11,  b: 7'd11,  p: 14'd121,   ovf: 1'b0};
    vecs[8] = '{a: 7'd127, b: 7'd1,   p: 14'd127,   ovf: 1'b0};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_p", 32'(p), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].ovf, 1);
      wait_done("table", 0);
    end

    // start re-pulsed mid-run must neither restart nor add a second done
    launch(7'd5, 7'd6, 14'd30, 1'b0, 1);
    wait_done("repulse", 3);
    repeat (12) @(posedge clk);

    // reset during the third RUN cycle aborts with no done
    launch(7'd9, 7'd9, 14'd81, 1'b0, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_p", 32'(p), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_idle_busy", 32'(busy), 32'd0);

    // back-to-back: start held through DONE of 2*3 launches 4*5
    @(posedge clk); #1;
    a = 7'd2; b = 7'd3; start = 1'b1;
    sb.push_back('{p: 14'd6, ovf: 1'b0});
    @(posedge clk); #1;
    a = 7'd4; b = 7'd5;
    sb.push_back('{p: 14'd20, ovf: 1'b0});
    wait_done("b2b_first", 0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b_second", 0);

    for (int i = 0; i < 1000; i++) begin
      ra   = 7'($urandom_range(0, 127));
      rb   = 7'($urandom_range(0, 127));
      prod = {7'd0, ra} * {7'd0, rb};
      launch(ra, rb, prod, |prod[2*W-1:W], 1);
      wait_done("rand", 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
